// File: rtl/keypad_debounce_decoder_if.sv
// Keypad scanner <-> debounce/decoder signal bundle.
// The scanner (master) presents the row/column snapshot; the decoder (slave)
// answers with the hold request and the decoded key.
interface keypad_debounce_decoder_if;
  logic [3:0] row_idx;       // one-hot, active-high row being driven
  logic [3:0] col_sync;      // synchronized columns, active-low
  logic       key_detected;  // some column is low in the current row
  logic       scan_stop;     // scanner must hold its current row
  logic       key_valid;     // one-cycle pulse per accepted press
  logic [3:0] key_code;      // hex code of the last accepted key
  logic       key_held;      // accepted key is still down

  modport master (
    output row_idx, col_sync, key_detected,
    input  scan_stop, key_valid, key_code, key_held
  );

  modport slave (
    input  row_idx, col_sync, key_detected,
    output scan_stop, key_valid, key_code, key_held
  );
endinterface

// File: rtl/keypad_debounce_decoder.sv
// 4x4 keypad debounce and decode.
// Locks onto a single pressed key, requires DEBOUNCE_CYCLES stable low samples
// to accept it (one key_valid pulse), then DEBOUNCE_CYCLES consecutive high
// samples to release it. Only the locked column is watched while a key is
// locked, so other keys are ignored (no rollover).
module keypad_debounce_decoder #(
  parameter int DEBOUNCE_CYCLES = 20000
) (
  input  logic                      clk,
  input  logic                      rst_n,
  keypad_debounce_decoder_if.slave  kp
);

  // Counter only ever needs to reach DEBOUNCE_CYCLES-1.
  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] PRESS_LAST = CW'(DEBOUNCE_CYCLES - 1);
  // The first high sample moves PRESSED -> DB_RELEASE and counts as one of
  // the release samples, so DB_RELEASE needs DEBOUNCE_CYCLES-1 more.
  localparam logic [CW-1:0] REL_LAST   = CW'(DEBOUNCE_CYCLES - 2);
  localparam logic [CW-1:0] CNT_MAX    = {CW{1'b1}};

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    DB_PRESS   = 2'd1,
    PRESSED    = 2'd2,
    DB_RELEASE = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      row_q, row_d;
  logic [1:0]      col_q, col_d;
  logic            scan_stop_q, scan_stop_d;
  logic            key_valid_q, key_valid_d;
  logic [3:0]      key_code_q, key_code_d;
  logic            key_held_q, key_held_d;

  logic            cand_ok;
  logic            mon_low;

  function automatic logic onehot4(input logic [3:0] v);
    onehot4 = (v != 4'h0) && ((v & (v - 4'h1)) == 4'h0);
  endfunction

  function automatic logic [1:0] enc4(input logic [3:0] v);
    enc4 = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (v[i]) enc4 = 2'(i);
    end
  endfunction

  function automatic logic [3:0] keymap(input logic [1:0] r, input logic [1:0] c);
    case ({r, c})
      4'h0: keymap = 4'h1;  4'h1: keymap = 4'h2;  4'h2: keymap = 4'h3;  4'h3: keymap = 4'hA;
      4'h4: keymap = 4'h4;  4'h5: keymap = 4'h5;  4'h6: keymap = 4'h6;  4'h7: keymap = 4'hB;
      4'h8: keymap = 4'h7;  4'h9: keymap = 4'h8;  4'hA: keymap = 4'h9;  4'hB: keymap = 4'hC;
      4'hC: keymap = 4'hE;  4'hD: keymap = 4'h0;  4'hE: keymap = 4'hF;  default: keymap = 4'hD;
    endcase
  endfunction

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    sat_inc = (v == CNT_MAX) ? v : v + CW'(1);
  endfunction

  // Candidate qualification and level of the locked column.
  always_comb begin
    cand_ok = kp.key_detected && onehot4(kp.row_idx) && onehot4(~kp.col_sync);
    mon_low = ~kp.col_sync[col_q];
  end

  // Next-state and output decode.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    row_d       = row_q;
    col_d       = col_q;
    key_valid_d = 1'b0;
    key_code_d  = key_code_q;
    key_held_d  = key_held_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (cand_ok) begin
          state_d = DB_PRESS;
          row_d   = enc4(kp.row_idx);
          col_d   = enc4(~kp.col_sync);
        end
      end
      DB_PRESS: begin
        if (!mon_low) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == PRESS_LAST) begin
          state_d     = PRESSED;
          cnt_d       = '0;
          key_code_d  = keymap(row_q, col_q);
          key_valid_d = 1'b1;
          key_held_d  = 1'b1;
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end
      PRESSED: begin
        cnt_d = '0;
        if (!mon_low) state_d = DB_RELEASE;
      end
      DB_RELEASE: begin
        if (mon_low) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == REL_LAST) begin
          state_d    = IDLE;
          cnt_d      = '0;
          key_held_d = 1'b0;
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    scan_stop_d = (state_d != IDLE);
  end

  // State and registered outputs; reset clears everything immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      row_q       <= 2'd0;
      col_q       <= 2'd0;
      scan_stop_q <= 1'b0;
      key_valid_q <= 1'b0;
      key_code_q  <= 4'h0;
      key_held_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      row_q       <= row_d;
      col_q       <= col_d;
      scan_stop_q <= scan_stop_d;
      key_valid_q <= key_valid_d;
      key_code_q  <= key_code_d;
      key_held_q  <= key_held_d;
    end
  end

  assign kp.scan_stop = scan_stop_q;
  assign kp.key_valid = key_valid_q;
  assign kp.key_code  = key_code_q;
  assign kp.key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_debounce_decoder.sv
// Bench for keypad_debounce_decoder with DEBOUNCE_CYCLES=4.
// A run-length model (lock / accept after DC low samples / release after DC
// high samples) is compared against the DUT every cycle, plus literal checks
// for the directed scenarios.
module tb_keypad_debounce_decoder;
  localparam int DC = 4;
  localparam bit [3:0] KMAP [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                                     4'h4, 4'h5, 4'h6, 4'hB,
                                     4'h7, 4'h8, 4'h9, 4'hC,
                                     4'hE, 4'h0, 4'hF, 4'hD};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  keypad_debounce_decoder_if kif();

  keypad_debounce_decoder #(.DEBOUNCE_CYCLES(DC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .kp    (kif)
  );

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    bit       locked;   // a key is being tracked (scanner held)
    bit       acc;      // tracked key has been accepted
    int       run;      // consecutive stable samples toward the next decision
    int       row;
    int       col;
    bit [3:0] code;
    bit       pulse;
  } model_t;

  model_t m;

  function automatic int idx4(input logic [3:0] v);
    idx4 = 0;
    for (int i = 0; i < 4; i++) if (v[i]) idx4 = i;
  endfunction

  function automatic model_t model_next(input model_t cur, input logic [3:0] row,
                                        input logic [3:0] col, input logic kd);
    model_t n;
    bit low;
    n = cur;
    n.pulse = 1'b0;
    if (!cur.locked) begin
      if (kd && $countones(row) == 1 && $countones(~col) == 1) begin
        n.locked = 1'b1; n.acc = 1'b0; n.run = 0;
        n.row = idx4(row); n.col = idx4(~col);
      end
    end else begin
      low = (col[cur.col] == 1'b0);
      if (!cur.acc) begin
        if (!low) n.locked = 1'b0;
        else begin
          n.run = cur.run + 1;
          if (n.run == DC) begin
            n.acc = 1'b1; n.run = 0; n.pulse = 1'b1;
            n.code = KMAP[cur.row * 4 + cur.col];
          end
        end
      end else begin
        if (low) n.run = 0;
        else begin
          n.run = cur.run + 1;
          if (n.run == DC) begin
            n.locked = 1'b0; n.acc = 1'b0; n.run = 0;
          end
        end
      end
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= '{default: 0};
    else        m <= model_next(m, kif.row_idx, kif.col_sync, kif.key_detected);
  end

  // ---------------- per-cycle compare and observers ----------------
  int cyc = 0;
  int pulses = 0;
  int kv_cyc = -1;
  int drop_cyc = -1;
  logic held_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      check("scan_stop", 32'(kif.scan_stop), 32'(m.locked));
      check("key_valid", 32'(kif.key_valid), 32'(m.pulse));
      check("key_code",  32'(kif.key_code),  32'(m.code));
      check("key_held",  32'(kif.key_held),  32'(m.acc));
    end
  end

  always @(negedge clk) begin
    if (rst_n && kif.key_valid) begin
      pulses <= pulses + 1;
      kv_cyc <= cyc;
    end
    if (held_prev && !kif.key_held) drop_cyc <= cyc;
    held_prev <= kif.key_held;
  end

  // Inputs are set, then held across the next rising edge; returns 2 ns after it.
  task automatic step(input logic [3:0] row, input logic [3:0] col, input logic kd);
    kif.row_idx      = row;
    kif.col_sync     = col;
    kif.key_detected = kd;
    @(posedge clk);
    #2;
  endtask

  task automatic step_n(input logic [3:0] row, input logic [3:0] col, input int n);
    for (int i = 0; i < n; i++) step(row, col, col != 4'hF);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_scan_stop"}, 32'(kif.scan_stop), 32'h0);
    check({tag, "_key_valid"}, 32'(kif.key_valid), 32'h0);
    check({tag, "_key_code"},  32'(kif.key_code),  32'h0);
    check({tag, "_key_held"},  32'(kif.key_held),  32'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int a, p0, last_low;
    int r, e, cur_row, cur_col;
    bit pressed;
    logic [3:0] row, col;
    logic kd;

    kif.row_idx = 4'b0001; kif.col_sync = 4'hF; kif.key_detected = 1'b0;
    #3;
    check_reset_outputs("reset");
    #9 rst_n = 1'b1;  // between edges

    // Clean press of key 1.
    step(4'b0001, 4'b1110, 1'b1);
    a = cyc;
    check("press_scan_stop_next", 32'(kif.scan_stop), 32'h1);
    step_n(4'b0001, 4'b1110, 9);
    check("press_pulses", 32'(pulses), 32'd1);
    check("press_latency", 32'(kv_cyc - a), 32'(DC));
    check("press_code", 32'(kif.key_code), 32'h1);
    check("press_held", 32'(kif.key_held), 32'h1);

    // Second key while key 1 held: ignored.
    step_n(4'b0001, 4'b1010, 4);
    check("second_pulses", 32'(pulses), 32'd1);
    check("second_code", 32'(kif.key_code), 32'h1);
    step_n(4'b0001, 4'hF, 6);
    check("release_held", 32'(kif.key_held), 32'h0);
    check("release_scan_stop", 32'(kif.scan_stop), 32'h0);

    // Bounce reject on key 5.
    step_n(4'b0010, 4'b1101, 2);
    step_n(4'b0010, 4'hF, 3);
    check("bounce_pulses", 32'(pulses), 32'd1);
    check("bounce_code", 32'(kif.key_code), 32'h1);
    check("bounce_scan_stop", 32'(kif.scan_stop), 32'h0);

    // Release bounce on key 5.
    p0 = pulses;
    step_n(4'b0010, 4'b1101, 6);
    check("k5_code", 32'(kif.key_code), 32'h5);
    last_low = 0;
    for (int i = 0; i < 6; i++) begin
      step(4'b0010, (i % 2 == 0) ? 4'hF : 4'b1101, 1'b1);
      if (i % 2 == 1) last_low = cyc;
    end
    step_n(4'b0010, 4'hF, 6);
    check("k5_pulses", 32'(pulses - p0), 32'd1);
    check("k5_drop_delay", 32'(drop_cyc - last_low), 32'(DC));
    check("k5_idle", 32'(kif.scan_stop), 32'h0);

    // Invalid candidates: two low columns, two rows.
    step(4'b0001, 4'b1100, 1'b1);
    step(4'b0001, 4'b1100, 1'b1);
    check("multi_col_scan_stop", 32'(kif.scan_stop), 32'h0);
    step(4'b0011, 4'b1110, 1'b1);
    check("multi_row_scan_stop", 32'(kif.scan_stop), 32'h0);
    step(4'b0001, 4'hF, 1'b0);

    // Asynchronous reset during DB_PRESS of key C.
    step(4'b0100, 4'b0111, 1'b1);
    step(4'b0100, 4'b0111, 1'b1);
    check("midrst_before", 32'(kif.scan_stop), 32'h1);
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("midrst");
    @(negedge clk);
    #1 rst_n = 1'b1;
    step_n(4'b0100, 4'b0111, 6);
    check("post_reset_code", 32'(kif.key_code), 32'hC);
    step_n(4'b0001, 4'hF, 6);

    // Randomized bouncing keys, checked every cycle by the model.
    cur_row = 0; cur_col = 0; pressed = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      if (r < 4) begin
        cur_row = $urandom_range(0, 3);
        cur_col = $urandom_range(0, 3);
      end else if (r < 22) begin
        pressed = !pressed;
      end
      row = 4'b0001 << cur_row;
      col = pressed ? ~(4'b0001 << cur_col) : 4'hF;
      e = $urandom_range(0, 99);
      if (e < 4)      col[$urandom_range(0, 3)] = 1'b0;
      else if (e < 6) row = row | (4'b0001 << $urandom_range(0, 3));
      kd = (col != 4'hF);
      if ($urandom_range(0, 99) < 3) kd = !kd;
      if (i == 1500) begin
        #1 rst_n = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b1;
      end
      step(row, col, kd);
    end

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
